// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EXE operand forwarding, load-use/miss stall control and stall statistics
module hazard_forward_unit #(
  parameter int XLEN         = 32,
  parameter int AW           = 5,
  parameter int NUM_RS       = 2,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_RS-1:0]      exe_rs_read_i,
  input  logic [NUM_RS*AW-1:0]   exe_rs_addr_i,
  input  logic [NUM_RS*XLEN-1:0] exe_rs_data_i,
  output logic [NUM_RS*XLEN-1:0] exe_rs_data_o,
  input  logic                   exe_flush_i,
  input  logic                   mem_alu_writeback_i,
  input  logic                   mem_mem_read_i,
  input  logic                   mem_mem_hit_i,
  input  logic [AW-1:0]          mem_rd_addr_i,
  input  logic [XLEN-1:0]        mem_alu_result_i,
  input  logic                   wb_writeback_i,
  input  logic [AW-1:0]          wb_rd_addr_i,
  input  logic [XLEN-1:0]        wb_rd_data_i,
  output logic                   stall_o,
  output logic                   mem_stall_o,
  output logic                   bubble_o,
  output logic                   miss_timeout_o,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            fwd_cnt_o
);

  localparam int MCW = ($clog2(MISS_TIMEOUT + 1) > 8) ? $clog2(MISS_TIMEOUT + 1) : 8;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LU   = 2'd1,
    MISS = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [NUM_RS-1:0] lu_vec, sel_mem, sel_wb, sel_hold;
  logic             lu, fwd_any;
  logic [MCW-1:0]   miss_cnt_q;
  logic [31:0]      stall_cnt_q, fwd_cnt_q;

  for (genvar g = 0; g < NUM_RS; g++) begin : g_port
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rf_data;
    logic [XLEN-1:0] op;
    logic            act;
    logic            h_valid;
    logic [AW-1:0]   h_addr;
    logic [XLEN-1:0] h_data;

    assign addr    = exe_rs_addr_i[g*AW +: AW];
    assign rf_data = exe_rs_data_i[g*XLEN +: XLEN];
    assign act     = exe_rs_read_i[g] && (addr != '0);

    assign sel_mem[g]  = act && mem_alu_writeback_i && (mem_rd_addr_i == addr);
    assign sel_wb[g]   = act && !sel_mem[g] && wb_writeback_i && (wb_rd_addr_i == addr);
    assign sel_hold[g] = act && !sel_mem[g] && !sel_wb[g] && h_valid && (h_addr == addr);
    assign lu_vec[g]   = act && mem_mem_read_i && (mem_rd_addr_i == addr);

    always_comb begin
      op = rf_data;
      if (!exe_rs_read_i[g])  op = rf_data;
      else if (addr == '0)    op = '0;
      else if (sel_mem[g])    op = mem_alu_result_i;
      else if (sel_wb[g])     op = wb_rd_data_i;
      else if (sel_hold[g])   op = h_data;
    end

    assign exe_rs_data_o[g*XLEN +: XLEN] = op;

    // WB data retires while EXE is frozen, so keep a copy for the rest of the stall
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        h_valid <= 1'b0;
        h_addr  <= '0;
        h_data  <= '0;
      end else if (!stall_o || exe_flush_i) begin
        h_valid <= 1'b0;
      end else if (sel_wb[g]) begin
        h_valid <= 1'b1;
        h_addr  <= wb_rd_addr_i;
        h_data  <= wb_rd_data_i;
      end
    end
  end

  assign lu          = (|lu_vec) && !exe_flush_i;
  assign mem_stall_o = !mem_mem_hit_i;
  assign stall_o     = mem_stall_o | lu;
  assign bubble_o    = lu & mem_mem_hit_i;
  assign fwd_any     = |(sel_mem | sel_wb | sel_hold);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    if (!mem_mem_hit_i) state_nxt = MISS;
    else if (lu)        state_nxt = LU;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      miss_cnt_q     <= '0;
      miss_timeout_o <= 1'b0;
    end else if (state == MISS && !mem_mem_hit_i) begin
      if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      if (miss_cnt_q == MCW'(MISS_TIMEOUT - 1)) miss_timeout_o <= 1'b1;
    end else begin
      miss_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_o && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (fwd_any && fwd_cnt_q != 32'hFFFF_FFFF)   fwd_cnt_q   <= fwd_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int NUM_RS = 2;
  localparam int MT     = 255;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_RS-1:0]      rs_read;
  logic [NUM_RS*AW-1:0]   rs_addr;
  logic [NUM_RS*XLEN-1:0] rs_data;
  logic [NUM_RS*XLEN-1:0] rs_out;
  logic                   flush, mem_alu_wb, mem_read, mem_hit;
  logic [AW-1:0]          mem_rd;
  logic [XLEN-1:0]        mem_res;
  logic                   wb_we;
  logic [AW-1:0]          wb_rd;
  logic [XLEN-1:0]        wb_data;
  logic                   stall, mem_stall, bubble, timeout;
  logic [31:0]            stall_cnt, fwd_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .XLEN(XLEN), .AW(AW), .NUM_RS(NUM_RS), .MISS_TIMEOUT(MT)
  ) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .exe_rs_read_i       (rs_read),
    .exe_rs_addr_i       (rs_addr),
    .exe_rs_data_i       (rs_data),
    .exe_rs_data_o       (rs_out),
    .exe_flush_i         (flush),
    .mem_alu_writeback_i (mem_alu_wb),
    .mem_mem_read_i      (mem_read),
    .mem_mem_hit_i       (mem_hit),
    .mem_rd_addr_i       (mem_rd),
    .mem_alu_result_i    (mem_res),
    .wb_writeback_i      (wb_we),
    .wb_rd_addr_i        (wb_rd),
    .wb_rd_data_i        (wb_data),
    .stall_o             (stall),
    .mem_stall_o         (mem_stall),
    .bubble_o            (bubble),
    .miss_timeout_o      (timeout),
    .stall_cnt_o         (stall_cnt),
    .fwd_cnt_o           (fwd_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input logic rd, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    rs_read[p]             = rd;
    rs_addr[p*AW +: AW]    = a;
    rs_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic idle();
    rs_read = '0; rs_addr = '0; rs_data = '0;
    flush = 0; mem_alu_wb = 0; mem_read = 0; mem_hit = 1;
    mem_rd = '0; mem_res = '0; wb_we = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] op(input int p);
    return rs_out[p*XLEN +: XLEN];
  endfunction

  initial begin
    idle();
    rst_n = 0;
    #3;
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_fwd_cnt", fwd_cnt, 0);
    check("rst_timeout", timeout, 0);
    check("rst_state", dut.state, 0);
    check("rst_stall", stall, 0);
    #9 rst_n = 1;
    tick();

    // MEM ALU forward of x5
    mem_alu_wb = 1; mem_rd = 5; mem_res = 32'h1234;
    set_port(0, 1, 5, 32'h5555);
    set_port(1, 0, 5, 32'hAAAA);
    #1;
    check("alu_fwd_op0", op(0), 32'h1234);
    check("noread_op1", op(1), 32'hAAAA);
    check("alu_fwd_stall", stall, 0);
    tick();
    check("alu_fwd_cnt", fwd_cnt, 1);

    // MEM beats WB for the same register; WB alone is next
    mem_rd = 3; mem_res = 32'hA3; wb_we = 1; wb_rd = 3; wb_data = 32'hB3;
    set_port(0, 1, 3, 32'h33);
    set_port(1, 1, 3, 32'h44);
    #1;
    check("prio_mem_op0", op(0), 32'hA3);
    check("prio_mem_op1", op(1), 32'hA3);
    tick();
    mem_alu_wb = 0;
    #1;
    check("prio_wb_op0", op(0), 32'hB3);
    tick();
    check("prio_fwd_cnt", fwd_cnt, 3);
    idle();

    // load-use on port 1
    mem_read = 1; mem_rd = 7;
    set_port(1, 1, 7, 32'h70);
    #1;
    check("lu_stall", stall, 1);
    check("lu_bubble", bubble, 1);
    check("lu_mem_stall", mem_stall, 0);
    tick();
    check("lu_state", dut.state, 1);
    mem_read = 0; wb_we = 1; wb_rd = 7; wb_data = 32'h77;
    #1;
    check("lu_after_stall", stall, 0);
    check("lu_after_op1", op(1), 32'h77);
    tick();
    check("lu_state_run", dut.state, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    idle();

    // miss for 3 cycles, WB x9 only in the first
    mem_hit = 0; wb_we = 1; wb_rd = 9; wb_data = 32'hCAFE;
    set_port(0, 1, 9, 32'h1111);
    set_port(1, 1, 10, 32'h2222);
    #1;
    check("miss_op0_c1", op(0), 32'hCAFE);
    check("miss_stall", stall, 1);
    check("miss_bubble", bubble, 0);
    tick();
    wb_we = 0; wb_data = 32'hDEAD;
    #1;
    check("miss_op0_c2", op(0), 32'hCAFE);
    check("miss_op1_other", op(1), 32'h2222);
    tick();
    check("miss_op0_c3", op(0), 32'hCAFE);
    tick();
    check("miss_state", dut.state, 2);
    mem_hit = 1;
    #1;
    check("miss_hit_stall", stall, 0);
    tick();
    check("hold_cleared", op(0), 32'h1111);
    check("miss_stall_cnt", stall_cnt, 4);
    check("miss_fwd_cnt", fwd_cnt, 8);
    idle();

    // flush kills load-use and beats hold capture
    flush = 1; mem_read = 1; mem_rd = 7;
    set_port(0, 1, 7, 32'h70);
    #1;
    check("flush_stall", stall, 0);
    check("flush_bubble", bubble, 0);
    tick();
    mem_read = 0; mem_hit = 0; wb_we = 1; wb_rd = 9; wb_data = 32'hBEEF;
    set_port(0, 1, 9, 32'h1111);
    #1;
    check("flush_wb_op0", op(0), 32'hBEEF);
    tick();
    flush = 0; wb_we = 0;
    mem_alu_wb = 1; mem_rd = 0; mem_res = 32'hFFFF;
    set_port(1, 1, 0, 32'h3333);
    #1;
    check("flush_no_hold", op(0), 32'h1111);
    check("x0_op1", op(1), 0);
    tick();
    idle();
    tick();
    check("flush_stall_cnt", stall_cnt, 6);
    check("flush_fwd_cnt", fwd_cnt, 9);

    // miss watchdog boundary
    mem_hit = 0;
    for (int i = 0; i < MT; i++) tick();
    check("wd_not_yet", timeout, 0);
    tick();
    check("wd_set", timeout, 1);
    mem_hit = 1;
    tick();
    tick();
    check("wd_sticky", timeout, 1);
    check("wd_stall_cnt", stall_cnt, 6 + MT + 1);

    // saturation and async reset mid-miss
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    mem_hit = 0;
    tick();
    check("sat_reach", stall_cnt, 32'hFFFF_FFFF);
    tick();
    check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    #2;
    rst_n = 0;
    #1;
    check("arst_state", dut.state, 0);
    check("arst_stall_cnt", stall_cnt, 0);
    check("arst_fwd_cnt", fwd_cnt, 0);
    check("arst_timeout", timeout, 0);
    check("arst_stall_comb", stall, 1);
    #3 rst_n = 1;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
